reg_file_scoreboard: RTL and testbench

- 32 x 64-bit LEGv8 register file directly upstream and downstream of the execute-stage ALU: drives ALU BusA/BusB, captures ALU/memory result on BusW.
- Adds a per-register busy scoreboard so multi-cycle producers (loads, iterative multiply) mark a destination pending. The decode stage stalls on operand hazards.
- Write-to-read bypass lets a value written in cycle N be used by the ALU in cycle N without an extra bubble.

---
 rtl/reg_file_scoreboard_if.sv | 29 ++
 rtl/reg_file_scoreboard.sv | 76 +++++++
 tb/tb_reg_file_scoreboard.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_scoreboard_if.sv
// Operand/result bus between decode, the register file and the execute-stage ALU.
// The master side issues read/write/busy requests; the slave side is the register file.
interface reg_file_scoreboard_if #(
  parameter int WIDTH = 64,
  parameter int AW    = 5
);
  logic [AW-1:0]    ra;
  logic [AW-1:0]    rb;
  logic [WIDTH-1:0] busA;
  logic [WIDTH-1:0] busB;
  logic             busyA;
  logic             busyB;
  logic [AW-1:0]    rw;
  logic [WIDTH-1:0] busW;
  logic             regWr;
  logic             setBusy;
  logic [AW-1:0]    sb;
  logic             stall;

  modport master (
    output ra, rb, rw, busW, regWr, setBusy, sb,
    input  busA, busB, busyA, busyB, stall
  );

  modport slave (
    input  ra, rb, rw, busW, regWr, setBusy, sb,
    output busA, busB, busyA, busyB, stall
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// LEGv8 register file with a per-register busy scoreboard and write-to-read bypass.
// X31 (XZR) reads as zero and is never written or marked busy.
module reg_file_scoreboard #(
  parameter int WIDTH = 64,
  parameter int NREG  = 32,
  parameter int AW    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_file_scoreboard_if.slave  bus
);

  localparam logic [AW-1:0] ZeroIdx = AW'(NREG - 1);

  logic [WIDTH-1:0] regsQ [NREG];
  logic [WIDTH-1:0] regsD [NREG];
  logic [NREG-1:0]  busyQ;
  logic [NREG-1:0]  busyD;

  logic writeEn;
  logic setEn;
  logic bypassA;
  logic bypassB;

  assign writeEn = bus.regWr   && (bus.rw != ZeroIdx);
  assign setEn   = bus.setBusy && (bus.sb != ZeroIdx);

  // A retiring write clears busy, but a new producer issued at the same edge re-arms it.
  always_comb begin
    regsD = regsQ;
    busyD = busyQ;
    if (writeEn) begin
      regsD[bus.rw] = bus.busW;
      busyD[bus.rw] = 1'b0;
    end
    if (setEn) begin
      busyD[bus.sb] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regsQ[i] <= '0;
      end
      busyQ <= '0;
    end else begin
      regsQ <= regsD;
      busyQ <= busyD;
    end
  end

  assign bypassA = bus.regWr && (bus.rw == bus.ra);
  assign bypassB = bus.regWr && (bus.rw == bus.rb);

  // Reset masks the bypass path too, so outputs read zero the instant reset rises.
  always_comb begin
    bus.busA  = '0;
    bus.busB  = '0;
    bus.busyA = 1'b0;
    bus.busyB = 1'b0;
    if (!rst) begin
      if (bus.ra != ZeroIdx) begin
        bus.busA  = bypassA ? bus.busW : regsQ[bus.ra];
        bus.busyA = busyQ[bus.ra] && !bypassA;
      end
      if (bus.rb != ZeroIdx) begin
        bus.busB  = bypassB ? bus.busW : regsQ[bus.rb];
        bus.busyB = busyQ[bus.rb] && !bypassB;
      end
    end
  end

  assign bus.stall = bus.busyA || bus.busyB;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard: stimulus queues hand-computed expectations,
// an independent monitor pops and compares them against the live outputs.
module tb_reg_file_scoreboard;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic        busyA;
    logic        busyB;
    logic        stall;
  } exp_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  exp_t  expQ[$];
  string nameQ[$];
  event  sampleEv;

  reg_file_scoreboard_if #(.WIDTH(64), .AW(5)) rfIf();

  reg_file_scoreboard #(.WIDTH(64), .NREG(32), .AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rfIf)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic cmp(input string name, input string field, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, act, exp);
    end
  endtask

  // Monitor: samples the DUT 1ns after each request and drains every pending expectation.
  initial begin
    exp_t  e;
    string n;
    forever begin
      @(sampleEv);
      #1;
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        cmp(n, "busA",  rfIf.busA,  e.a);
        cmp(n, "busB",  rfIf.busB,  e.b);
        cmp(n, "busyA", {63'd0, rfIf.busyA}, {63'd0, e.busyA});
        cmp(n, "busyB", {63'd0, rfIf.busyB}, {63'd0, e.busyB});
        cmp(n, "stall", {63'd0, rfIf.stall}, {63'd0, e.stall});
      end
    end
  end

  task automatic applyStimulus(input logic regWr, input logic [4:0] rw, input logic [63:0] busW,
                               input logic setBusy, input logic [4:0] sb,
                               input logic [4:0] ra, input logic [4:0] rb);
    rfIf.regWr   = regWr;
    rfIf.rw      = rw;
    rfIf.busW    = busW;
    rfIf.setBusy = setBusy;
    rfIf.sb      = sb;
    rfIf.ra      = ra;
    rfIf.rb      = rb;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] a, input logic [63:0] b,
                             input logic busyA, input logic busyB);
    exp_t e;
    e.a     = a;
    e.b     = b;
    e.busyA = busyA;
    e.busyB = busyB;
    e.stall = busyA | busyB;
    expQ.push_back(e);
    nameQ.push_back(name);
    -> sampleEv;
    #3;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    #2;
    checkOutput("reset_state", 64'd0, 64'd0, 1'b0, 1'b0);

    nextCycle();
    rst = 1'b0;

    // reg[3] = 0x1234, then an asynchronous reset mid-cycle must clear it without a clock
    nextCycle();
    applyStimulus(1'b1, 5'd3, 64'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd3, 5'd3);
    checkOutput("write_reg3", 64'h1234, 64'h1234, 1'b0, 1'b0);
    rst = 1'b1;
    checkOutput("async_reset_reg3", 64'd0, 64'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // XZR: write dropped, reads zero even with a matching bypass
    nextCycle();
    applyStimulus(1'b1, 5'd31, 64'hFFFF, 1'b0, 5'd0, 5'd31, 5'd31);
    checkOutput("xzr_bypass", 64'd0, 64'd0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd31, 5'd31);
    checkOutput("xzr_after_write", 64'd0, 64'd0, 1'b0, 1'b0);

    // Successive writes then a two-port read
    nextCycle();
    applyStimulus(1'b1, 5'd5, 64'h4321, 1'b0, 5'd0, 5'd0, 5'd0);
    nextCycle();
    applyStimulus(1'b1, 5'd6, 64'h1234, 1'b0, 5'd0, 5'd0, 5'd0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd5, 5'd6);
    checkOutput("read_5_6", 64'h4321, 64'h1234, 1'b0, 1'b0);

    // Same-cycle bypass, then the stored value after the edge
    nextCycle();
    applyStimulus(1'b1, 5'd7, 64'hABCD, 1'b0, 5'd0, 5'd7, 5'd6);
    checkOutput("bypass_7", 64'hABCD, 64'h1234, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd7, 5'd5);
    checkOutput("stored_7", 64'hABCD, 64'h4321, 1'b0, 1'b0);

    // Scoreboard: busy only after the edge, cleared by a bypassing write
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd0, 5'd9);
    checkOutput("setbusy9_before_edge", 64'd0, 64'd0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd9);
    checkOutput("busy9_stall", 64'd0, 64'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 5'd9, 64'h55, 1'b0, 5'd0, 5'd0, 5'd9);
    checkOutput("busy9_bypass", 64'd0, 64'h55, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd0, 5'd9);
    checkOutput("busy9_cleared", 64'd0, 64'h55, 1'b0, 1'b0);

    // SetBusy and RegWr on the same index: data written, busy stays set
    nextCycle();
    applyStimulus(1'b1, 5'd4, 64'h10, 1'b1, 5'd4, 5'd4, 5'd0);
    checkOutput("set_clear_4_same_cycle", 64'h10, 64'd0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd4, 5'd4);
    checkOutput("set_wins_4", 64'h10, 64'h10, 1'b1, 1'b1);

    // XZR cannot be marked busy
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 5'd31, 5'd4);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd31, 5'd4);
    checkOutput("xzr_never_busy", 64'd0, 64'h10, 1'b0, 1'b1);

    // Repeated SetBusy does not count: one retiring write clears it
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 5'd4, 5'd4);
    nextCycle();
    applyStimulus(1'b1, 5'd4, 64'h20, 1'b0, 5'd0, 5'd4, 5'd4);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd4, 5'd4);
    checkOutput("no_busy_count_4", 64'h20, 64'h20, 1'b0, 1'b0);

    // SetBusy and RegWr on different indices take effect independently
    nextCycle();
    applyStimulus(1'b1, 5'd8, 64'h88, 1'b1, 5'd2, 5'd2, 5'd8);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd8, 5'd2, 5'd8);
    checkOutput("independent_2_8", 64'd0, 64'h88, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd2, 5'd8);
    checkOutput("busy_2_and_8", 64'd0, 64'h88, 1'b1, 1'b1);
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd8, 5'd8);
    checkOutput("ra_eq_rb_8", 64'h88, 64'h88, 1'b1, 1'b1);

    // Reset mid-operation, held across an edge with a write that must be discarded
    applyStimulus(1'b1, 5'd2, 64'h77, 1'b1, 5'd5, 5'd2, 5'd8);
    rst = 1'b1;
    checkOutput("reset_mid_op", 64'd0, 64'd0, 1'b0, 1'b0);
    nextCycle();
    rst = 1'b0;
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd2, 5'd5);
    checkOutput("write_during_reset_dropped", 64'd0, 64'd0, 1'b0, 1'b0);

    // Bounded drain of the scoreboard before reporting
    for (int i = 0; i < 20 && expQ.size() > 0; i++) #1;
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
